// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcode field location, HALT encoding and fetch FSM states.
package lc2k_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned OPC_MSB = 24;
    localparam int unsigned OPC_LSB = 22;
    localparam logic [2:0]  OPC_HALT = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/lc2k_fetch_unit.sv
// LC2K instruction fetch: owns the PC, reads imem over req/ack and hands
// instructions to decode over valid/ready; honours redirects and stops on halt.
module lc2k_fetch_unit
    import lc2k_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_word,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_plus_one,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_drop;
    logic [INST_W-1:0] r_inst_word;
    logic [ADDR_W-1:0] r_inst_pc;

    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_is_halt;

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_is_halt = (r_inst_word[OPC_MSB:OPC_LSB] == OPC_HALT);

    // r_addr is the address on the bus; it only follows r_pc once the
    // outstanding request has been acked, so a pending redirect lives in r_pc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst_word <= '0;
            r_inst_pc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr  <= r_pc;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        if (r_drop || redirect) begin
                            r_drop <= 1'b0;
                            if (redirect) begin
                                r_pc   <= redirect_pc;
                                r_addr <= redirect_pc;
                            end else begin
                                r_addr <= r_pc;
                            end
                        end else begin
                            r_inst_word <= imem_rdata;
                            r_inst_pc   <= r_pc;
                            r_state     <= S_HOLD;
                        end
                    end else if (redirect) begin
                        r_pc   <= redirect_pc;
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_addr  <= redirect_pc;
                        r_state <= S_REQ;
                    end else if (inst_ready) begin
                        r_pc    <= w_pc_inc;
                        r_addr  <= w_pc_inc;
                        r_state <= w_is_halt ? S_HALT : S_REQ;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req         = (r_state == S_REQ);
    assign inst_valid       = (r_state == S_HOLD);
    assign halted           = (r_state == S_HALT);
    assign imem_addr        = r_addr;
    assign inst_word        = r_inst_word;
    assign inst_pc          = r_inst_pc;
    assign inst_pc_plus_one = r_inst_pc + ADDR_W'(1);

endmodule

// File: tb/tb_lc2k_fetch_unit.sv
// Directed bench for lc2k_fetch_unit: sequential fetch, stalls, redirects,
// halt, and PC wrap with RESET_PC at the top of the address space.
module tb_lc2k_fetch_unit;

    localparam int unsigned AW = 16;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_word;
    logic [AW-1:0] inst_pc;
    logic [AW-1:0] inst_pc_plus_one;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halted;

    logic          rst_b;
    logic          req_b;
    logic [AW-1:0] addr_b;
    logic          ack_b;
    logic [31:0]   rdata_b;
    logic          valid_b;
    logic          ready_b;
    logic [31:0]   word_b;
    logic [AW-1:0] pc_b;
    logic [AW-1:0] pcp1_b;
    logic          redirect_b;
    logic [AW-1:0] redirect_pc_b;
    logic          halted_b;

    logic [31:0] mem [0:255];
    int unsigned ack_delay;
    int unsigned wait_cnt;
    int          n_checks;
    int          n_errors;

    lc2k_fetch_unit #(.ADDR_W(AW), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word), .inst_pc(inst_pc),
        .inst_pc_plus_one(inst_pc_plus_one),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    lc2k_fetch_unit #(.ADDR_W(AW), .RESET_PC(16'hFFFF)) u_dut_wrap (
        .clk(clk), .reset(rst_b),
        .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(ack_b), .imem_rdata(rdata_b),
        .inst_valid(valid_b), .inst_ready(ready_b),
        .inst_word(word_b), .inst_pc(pc_b),
        .inst_pc_plus_one(pcp1_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .halted(halted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after ack_delay cycles of continuous request.
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
    assign imem_rdata = mem[imem_addr[7:0]];
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    assign ack_b   = req_b;
    assign rdata_b = {16'hABCD, addr_b};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first request cycle after reset release.
    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        check_eq("rst_req",   32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_halt",  32'(halted), 32'd0);
        check_eq("rst_addr",  32'(imem_addr), 32'd0);
        check_eq("rst_pcp1",  32'(inst_pc_plus_one), 32'd1);
        check_eq("rst_ipc",   32'(inst_pc), 32'd0);
        check_eq("rst_word",  inst_word, 32'd0);
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_req(input logic [AW-1:0] a);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (imem_req && imem_addr == a) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("wait_req_seen", 32'(found), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        wait_cnt      = 0;
        ack_delay     = 0;
        reset         = 1'b1;
        inst_ready    = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        rst_b         = 1'b1;
        ready_b       = 1'b1;
        redirect_b    = 1'b0;
        redirect_pc_b = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + 32'(i);

        // Back-to-back fetch, same-cycle ack, ready tied high.
        ack_delay  = 0;
        inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check_eq("seq_req",   32'(imem_req), 32'd1);
            check_eq("seq_addr",  32'(imem_addr), 32'(i));
            tick();
            check_eq("seq_valid", 32'(inst_valid), 32'd1);
            check_eq("seq_ipc",   32'(inst_pc), 32'(i));
            check_eq("seq_pcp1",  32'(inst_pc_plus_one), 32'(i + 1));
            check_eq("seq_word",  inst_word, 32'h0000_1000 + 32'(i));
            tick();
        end

        // Slow memory and stalled decode.
        ack_delay  = 3;
        inst_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_req",   32'(imem_req), 32'd1);
            check_eq("stall_addr",  32'(imem_addr), 32'd0);
            check_eq("stall_valid", 32'(inst_valid), 32'd0);
            tick();
        end
        check_eq("stall_ack", 32'(imem_ack), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("hold_valid", 32'(inst_valid), 32'd1);
            check_eq("hold_ipc",   32'(inst_pc), 32'd0);
            check_eq("hold_word",  inst_word, 32'h0000_1000);
            check_eq("hold_req",   32'(imem_req), 32'd0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check_eq("rel_valid", 32'(inst_valid), 32'd0);
        check_eq("rel_req",   32'(imem_req), 32'd1);
        check_eq("rel_addr",  32'(imem_addr), 32'd1);

        // Redirect one cycle into a pending request to address 5.
        ack_delay  = 3;
        inst_ready = 1'b1;
        do_reset();
        wait_req(16'd5);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check_eq("rdr_addr_kept", 32'(imem_addr), 32'd5);
        check_eq("rdr_valid0",    32'(inst_valid), 32'd0);
        tick();
        check_eq("rdr_ack_addr",  32'(imem_addr), 32'd5);
        check_eq("rdr_ack",       32'(imem_ack), 32'd1);
        tick();
        check_eq("rdr_valid1",    32'(inst_valid), 32'd0);
        check_eq("rdr_req",       32'(imem_req), 32'd1);
        check_eq("rdr_new_addr",  32'(imem_addr), 32'h40);
        repeat (3) tick();
        tick();
        check_eq("rdr_valid",     32'(inst_valid), 32'd1);
        check_eq("rdr_ipc",       32'(inst_pc), 32'h40);
        check_eq("rdr_word",      inst_word, 32'h0000_1040);

        // Redirect coinciding with ready while holding 0x40.
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        check_eq("hrdr_valid", 32'(inst_valid), 32'd0);
        check_eq("hrdr_req",   32'(imem_req), 32'd1);
        check_eq("hrdr_addr",  32'(imem_addr), 32'h10);
        repeat (3) tick();
        tick();
        check_eq("hrdr_ipc",   32'(inst_pc), 32'h10);
        check_eq("hrdr_pcp1",  32'(inst_pc_plus_one), 32'h11);

        // Halt at address 3.
        mem[3]     = 32'h0180_0000;
        ack_delay  = 0;
        inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check_eq("h_addr", 32'(imem_addr), 32'(i));
            tick();
            check_eq("h_ipc",  32'(inst_pc), 32'(i));
            check_eq("h_word", inst_word, mem[i]);
            tick();
        end
        check_eq("h_halted", 32'(halted), 32'd1);
        check_eq("h_valid",  32'(inst_valid), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check_eq("h_req_quiet", 32'(imem_req), 32'd0);
            check_eq("h_stay",      32'(halted), 32'd1);
            tick();
        end
        do_reset();
        check_eq("h_restart_req",  32'(imem_req), 32'd1);
        check_eq("h_restart_addr", 32'(imem_addr), 32'd0);
        mem[3] = 32'h0000_1003;

        // RESET_PC at the top of the address space wraps to 0.
        check_eq("w_rst_addr", 32'(addr_b), 32'hFFFF);
        check_eq("w_rst_pcp1", 32'(pcp1_b), 32'd1);
        rst_b = 1'b0;
        tick();
        check_eq("w_req0",  32'(req_b), 32'd1);
        check_eq("w_addr0", 32'(addr_b), 32'hFFFF);
        tick();
        check_eq("w_valid", 32'(valid_b), 32'd1);
        check_eq("w_ipc0",  32'(pc_b), 32'hFFFF);
        check_eq("w_pcp10", 32'(pcp1_b), 32'd0);
        check_eq("w_word0", word_b, 32'hABCD_FFFF);
        tick();
        check_eq("w_addr1", 32'(addr_b), 32'd0);
        tick();
        check_eq("w_ipc1",  32'(pc_b), 32'd0);
        check_eq("w_pcp11", 32'(pcp1_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc2k_fetch_unit.md
# lc2k_fetch_unit

Instruction fetch stage for the LC2K CPU, the consumer of the next-PC value. Owns the architectural PC register. Reads instruction memory over a req/ack handshake and presents each fetched instruction, with its PC and PC+1, to decode over a valid/ready handshake. Accepts branch/JALR redirects from execute and stops fetching permanently after a `halt` is consumed.

## Interface
- `ADDR_W`, 16, PC / instruction-memory word-address width
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  read request; held high until `imem_ack`
- `imem_addr`  out  ADDR_W  word address of the request; equals PC, stable while `imem_req`
- `imem_ack`  in  1  read complete; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  32  instruction word
- `inst_valid`  out  1  `inst_word`/`inst_pc`/`inst_pc_plus_one` valid
- `inst_ready`  in  1  decode accepts the instruction
- `inst_word`  out  32  fetched instruction
- `inst_pc`  out  ADDR_W  address `inst_word` was fetched from
- `inst_pc_plus_one`  out  ADDR_W  `inst_pc + 1`, modulo 2^ADDR_W
- `redirect`  in  1  single-cycle pulse: discard the in-flight fetch and restart at `redirect_pc`
- `redirect_pc`  in  ADDR_W  target, sampled only when `redirect` is high
- `halted`  out  1  a halt instruction has been consumed; fetch stopped

Clock and reset: one clock, `clk`. Reset `reset` is asynchronous and active-high.

## Operation
- States: `S_IDLE`, `S_REQ`, `S_HOLD`, `S_HALT`. `imem_req = (state==S_REQ)`, `inst_valid = (state==S_HOLD)`, `halted = (state==S_HALT)`. All three are decoded from the registered state.
- Registers: `pc`, `inst_word`, `inst_pc`, `drop` (1 bit, pending-discard flag).
- `S_IDLE` -> `S_REQ` unconditionally on the first clock after reset release.
- `S_REQ`:
  - Request `pc` and wait for `imem_ack`. The request is never withdrawn before ack.
  - On ack with no `drop` and no `redirect`: latch `imem_rdata` into `inst_word` and `pc` into `inst_pc`, then go to `S_HOLD`.
  - `redirect` before ack: `pc <= redirect_pc`, `drop <= 1`. `imem_addr` keeps the original address until ack, so the address register is separate from `pc`.
  - Ack with `drop` set or `redirect` high: discard data, clear `drop`, stay in `S_REQ`, and issue the new request next cycle at the redirect target.
  - A later redirect overrides an earlier pending one.
- `S_HOLD`:
  - Outputs are held stable until `inst_ready`.
  - On `inst_ready` without `redirect`: `pc <= pc + 1`. Go to `S_HALT` if `inst_word[24:22] == OPC_HALT`, otherwise go to `S_REQ`.
  - `redirect` (with or without `inst_ready`): the held instruction is dropped, `pc <= redirect_pc`, go to `S_REQ`. Redirect wins.
- `S_HALT`: terminal. `redirect`, `imem_ack`, and `inst_ready` are ignored. Leave only via `reset`.
- PC arithmetic is ADDR_W bits and wraps: PC 2^ADDR_W−1 is followed by 0.
- Stray `imem_ack` outside `S_REQ` is ignored.

## Timing
- Reset (asynchronous): state `S_IDLE`, `pc = RESET_PC`, `drop = 0`, `inst_word = 0`, `inst_pc = 0`. Outputs `imem_req = 0`, `inst_valid = 0`, `halted = 0`, `imem_addr = RESET_PC`, `inst_pc_plus_one = 1`.
- Reset asserted mid-operation aborts everything immediately. The memory must tolerate an abandoned request.
- First `imem_req` occurs in the first cycle after reset release.
- Ack in cycle N: `inst_valid` rises in N+1.
- Ready in cycle M: `inst_valid` falls in M+1, and `imem_req` is high in M+1 at the new PC.
- Best-case throughput: one instruction per 2 cycles.
- Redirect in `S_HOLD` at cycle R: `inst_valid` is low in R+1, and `imem_req` is high with `imem_addr = redirect_pc` in R+1.

## Structure
- Shared package `lc2k_pkg`: `OPC_HALT = 3'b110`, opcode field bounds `OPC_MSB = 24`, `OPC_LSB = 22`, and the fetch state enum `fetch_state_t`. Decode and control also use the opcode constants.
- Single module with no sub-modules. The FSM and datapath are small enough to keep together.

## Test plan
- Reset release, memory acks every request on the same cycle, `inst_ready` tied high, memory holds `add` at 0..2 -> `imem_addr` sequence 0,1,2; `inst_pc` 0,1,2; `inst_pc_plus_one` 1,2,3; a new instruction every 2 cycles.
- Ack delayed 3 cycles and `inst_ready` held low 4 cycles -> `imem_addr` stable during the wait; `inst_word`/`inst_pc` stable while valid and not ready.
- `redirect` with `redirect_pc=0x0040` one cycle into a pending request to address 5 -> data for 5 discarded, never valid; next request at 0x0040; next `inst_pc = 0x0040`.
- `redirect` (target 0x0010) in the same cycle as `inst_ready` in `S_HOLD` -> held instruction dropped, following request at 0x0010, no fetch from `inst_pc+1`.
- `halt` (0x01800000) at address 3 -> presented with `inst_pc=3`; after ready, `halted=1`, `imem_req` stays 0 for 20 cycles despite a `redirect`; `reset` returns PC to 0.
- `RESET_PC=16'hFFFF` -> fetch from 0xFFFF, then 0x0000 (wrap); `inst_pc_plus_one=0` for the first instruction.
